// File: rtl/pkt_capture_writer_if.sv
// Capture-stream sink and Avalon-MM write-master signals of pkt_capture_writer.
// The master modport is the writer's view; slave is the stream source / memory side.
interface pkt_capture_writer_if #(
   parameter int unsigned N = 32
) ();
   logic [N-1:0] st_data;
   logic         st_valid;
   logic         st_sop;
   logic         st_eop;
   logic         st_ready;
   logic [N-1:0] avm_address;
   logic         avm_write;
   logic [N-1:0] avm_writedata;
   logic         avm_waitrequest;

   modport master (
      input  st_data, st_valid, st_sop, st_eop, avm_waitrequest,
      output st_ready, avm_address, avm_write, avm_writedata
   );

   modport slave (
      output st_data, st_valid, st_sop, st_eop, avm_waitrequest,
      input  st_ready, avm_address, avm_write, avm_writedata
   );
endinterface

// File: rtl/pkt_capture_writer.sv
// Captures one packet from the capture stream into a host buffer over Avalon-MM,
// one word per beat, truncating (and flagging overflow) when the buffer fills.
module pkt_capture_writer #(
   parameter int unsigned N = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N-1:0]          ctrl,
   input  logic [N-1:0]          base_addr,
   input  logic [N-1:0]          buf_len,
   pkt_capture_writer_if.master  bus,
   output logic [1:0]            state,
   output logic [N-1:0]          captured_len,
   output logic                  overflow
);
   localparam int unsigned BYTES    = N / 8;
   localparam logic [N-1:0] WORD_INC = N'(BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_SOP, S_FETCH, S_WRITE, S_DRAIN, S_DONE
   } fsm_e;

   fsm_e         state_q, state_d;
   logic         arm_q;
   logic         eop_q;
   logic [N-1:0] base_q, len_q, count_q;
   logic         st_ready_q, avm_write_q;
   logic [N-1:0] avm_address_q, avm_writedata_q;
   logic         st_ready_d, avm_write_d;
   logic [1:0]   state_code_d;

   logic         arm_edge_c, beat_c, take_c, wr_done_c;
   logic [N-1:0] count_inc_c;
   logic         ctrl_unused;

   assign arm_edge_c  = ctrl[2] && !arm_q;
   assign beat_c      = bus.st_valid && st_ready_q;
   // Only the sop beat opens a packet; mid-packet sop is plain data
   assign take_c      = beat_c && ((state_q == S_WAIT_SOP && bus.st_sop) || state_q == S_FETCH);
   assign wr_done_c   = (state_q == S_WRITE) && avm_write_q && !bus.avm_waitrequest;
   assign count_inc_c = count_q + WORD_INC;
   assign ctrl_unused = ^{ctrl[N-1:4], ctrl[1:0]};

   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state plus the next values of the registered handshake/status outputs
   always_comb begin
      state_d      = state_q;
      st_ready_d   = 1'b0;
      avm_write_d  = 1'b0;
      state_code_d = 2'b00;
      case (state_q)
         S_IDLE:     if (arm_edge_c) state_d = (buf_len == '0) ? S_DONE : S_WAIT_SOP;
         S_WAIT_SOP: if (take_c) state_d = S_WRITE;
         S_FETCH:    if (take_c) state_d = S_WRITE;
         S_WRITE: begin
            if (wr_done_c) begin
               if (eop_q)                     state_d = S_DONE;
               else if (count_inc_c == len_q) state_d = S_DRAIN;
               else                           state_d = S_FETCH;
            end
         end
         S_DRAIN:    if (beat_c && bus.st_eop) state_d = S_DONE;
         S_DONE:     if (ctrl[3]) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
      case (state_d)
         S_WAIT_SOP: begin st_ready_d = 1'b1; state_code_d = 2'b01; end
         S_FETCH:    begin st_ready_d = 1'b1; state_code_d = 2'b10; end
         S_WRITE:    begin avm_write_d = 1'b1; state_code_d = 2'b10; end
         S_DRAIN:    begin st_ready_d = 1'b1; state_code_d = 2'b10; end
         S_DONE:     state_code_d = 2'b11;
         default:    state_code_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         arm_q           <= 1'b0;
         st_ready_q      <= 1'b0;
         avm_write_q     <= 1'b0;
         state           <= 2'b00;
         avm_address_q   <= '0;
         avm_writedata_q <= '0;
         eop_q           <= 1'b0;
         base_q          <= '0;
         len_q           <= '0;
         count_q         <= '0;
         captured_len    <= '0;
         overflow        <= 1'b0;
      end else begin
         arm_q       <= ctrl[2];
         st_ready_q  <= st_ready_d;
         avm_write_q <= avm_write_d;
         state       <= state_code_d;
         if (state_q == S_IDLE && arm_edge_c) begin
            base_q       <= base_addr;
            len_q        <= buf_len;
            count_q      <= '0;
            captured_len <= '0;
            overflow     <= 1'b0;
         end
         // Address and data only move on an accepted beat, so they hold across stalls
         if (take_c) begin
            avm_address_q   <= base_q + count_q;
            avm_writedata_q <= bus.st_data;
            eop_q           <= bus.st_eop;
         end
         if (wr_done_c) begin
            count_q      <= count_inc_c;
            captured_len <= count_inc_c;
            if (!eop_q && count_inc_c == len_q) overflow <= 1'b1;
         end
      end
   end

   assign bus.st_ready      = st_ready_q;
   assign bus.avm_write     = avm_write_q;
   assign bus.avm_address   = avm_address_q;
   assign bus.avm_writedata = avm_writedata_q;
endmodule

// File: tb/tb_pkt_capture_writer.sv
// Directed bench for pkt_capture_writer with a write scoreboard.
module tb_pkt_capture_writer;
   localparam int unsigned N = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ctrl, base_addr, buf_len;
   logic [1:0]  state;
   logic [31:0] captured_len;
   logic        overflow;

   pkt_capture_writer_if #(.N(N)) bus ();

   pkt_capture_writer #(.N(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .ctrl         (ctrl),
      .base_addr    (base_addr),
      .buf_len      (buf_len),
      .bus          (bus),
      .state        (state),
      .captured_len (captured_len),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_w;
   int  checks = 0;
   int  errors = 0;
   int  wr_count = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1ns after posedge, so the negedge view equals what the next edge samples
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.avm_write === 1'b1 && bus.avm_waitrequest === 1'b0) begin
         wr_count++;
         check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_w = exp_q.pop_front();
            check("wr_addr", bus.avm_address, mon_w.addr);
            check("wr_data", bus.avm_writedata, mon_w.data);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                            input bit expect_wr, input logic [31:0] addr);
      int n;
      if (expect_wr) exp_q.push_back(wr_t'{addr: addr, data: d});
      bus.st_data  = d;
      bus.st_sop   = sop;
      bus.st_eop   = eop;
      bus.st_valid = 1'b1;
      n = 0;
      while (bus.st_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check("st_ready_seen", bus.st_ready, 1);
      step();
      bus.st_valid = 1'b0;
      bus.st_sop   = 1'b0;
      bus.st_eop   = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [1:0] exp, input int budget);
      int n;
      n = 0;
      while (state !== exp && n < budget) begin
         step();
         n++;
      end
      check(tag, state, exp);
   endtask

   task automatic ack();
      ctrl = 32'h8;
      step();
      check("ack_idle", state, 2'b00);
      ctrl = 32'h0;
      step();
   endtask

   initial begin
      reset = 1'b0;
      ctrl = '0; base_addr = '0; buf_len = '0;
      bus.st_data = '0; bus.st_valid = 1'b0; bus.st_sop = 1'b0; bus.st_eop = 1'b0;
      bus.avm_waitrequest = 1'b0;
      step(3);
      check("rst_state", state, 2'b00);
      check("rst_st_ready", bus.st_ready, 0);
      check("rst_avm_write", bus.avm_write, 0);
      check("rst_addr", bus.avm_address, 0);
      check("rst_wdata", bus.avm_writedata, 0);
      check("rst_caplen", captured_len, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b1;
      step();

      // Basic 3-beat packet
      base_addr = 32'h1000; buf_len = 32'd64; ctrl = 32'h4;
      step();
      check("basic_armed", state, 2'b01);
      check("basic_ready", bus.st_ready, 1);
      ctrl = 32'h0;
      send_beat(32'hA000_0000, 1'b1, 1'b0, 1'b1, 32'h1000);
      check("basic_busy", state, 2'b10);
      check("basic_wr_up", bus.avm_write, 1);
      send_beat(32'hA000_0001, 1'b0, 1'b0, 1'b1, 32'h1004);
      send_beat(32'hA000_0002, 1'b0, 1'b1, 1'b1, 32'h1008);
      wait_state("basic_done", 2'b11, 10);
      check("basic_caplen", captured_len, 12);
      check("basic_ovf", overflow, 0);
      check("basic_nwr", wr_count, 3);
      ack();
      wr_count = 0;

      // Stall of 3 cycles on the second write
      ctrl = 32'h4;
      step();
      ctrl = 32'h0;
      send_beat(32'hB000_0000, 1'b1, 1'b0, 1'b1, 32'h1000);
      step();
      bus.avm_waitrequest = 1'b1;
      send_beat(32'hB000_0001, 1'b0, 1'b0, 1'b1, 32'h1004);
      for (int i = 0; i < 3; i++) begin
         check("stall_wr", bus.avm_write, 1);
         check("stall_addr", bus.avm_address, 32'h1004);
         check("stall_data", bus.avm_writedata, 32'hB000_0001);
         step();
      end
      bus.avm_waitrequest = 1'b0;
      send_beat(32'hB000_0002, 1'b0, 1'b1, 1'b1, 32'h1008);
      wait_state("stall_done", 2'b11, 10);
      check("stall_caplen", captured_len, 12);
      check("stall_nwr", wr_count, 3);
      ack();
      wr_count = 0;

      // Overflow: 8-byte buffer, 5-beat packet
      buf_len = 32'd8; ctrl = 32'h4;
      step();
      ctrl = 32'h0;
      send_beat(32'hC000_0000, 1'b1, 1'b0, 1'b1, 32'h1000);
      send_beat(32'hC000_0001, 1'b0, 1'b0, 1'b1, 32'h1004);
      send_beat(32'hC000_0002, 1'b0, 1'b0, 1'b0, 32'h0);
      check("ovf_draining", state, 2'b10);
      check("ovf_flag_mid", overflow, 1);
      send_beat(32'hC000_0003, 1'b0, 1'b0, 1'b0, 32'h0);
      send_beat(32'hC000_0004, 1'b0, 1'b1, 1'b0, 32'h0);
      wait_state("ovf_done", 2'b11, 5);
      check("ovf_flag", overflow, 1);
      check("ovf_caplen", captured_len, 8);
      check("ovf_nwr", wr_count, 2);
      ack();
      wr_count = 0;

      // Pre-sop garbage with arm held high throughout
      base_addr = 32'h2000; buf_len = 32'd64; ctrl = 32'h4;
      step();
      check("hold_armed", state, 2'b01);
      check("hold_ovf_cleared", overflow, 0);
      send_beat(32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 32'h0);
      send_beat(32'hDEAD_0001, 1'b0, 1'b1, 1'b0, 32'h0);
      check("hold_still_wait", state, 2'b01);
      send_beat(32'hD000_0000, 1'b1, 1'b0, 1'b1, 32'h2000);
      send_beat(32'hD000_0001, 1'b0, 1'b1, 1'b1, 32'h2004);
      wait_state("hold_done", 2'b11, 10);
      step(8);
      check("hold_stays_done", state, 2'b11);
      check("hold_caplen", captured_len, 8);
      check("hold_nwr", wr_count, 2);
      ctrl = 32'hC;
      step();
      check("hold_ack_idle", state, 2'b00);
      ctrl = 32'h4;
      step(3);
      check("hold_no_rearm", state, 2'b00);
      ctrl = 32'h0;
      step();
      wr_count = 0;

      // Zero-length buffer
      buf_len = 32'd0; ctrl = 32'h4;
      step();
      check("zero_done", state, 2'b11);
      check("zero_caplen", captured_len, 0);
      check("zero_ready", bus.st_ready, 0);
      step(2);
      check("zero_nwr", wr_count, 0);
      ack();

      // Reset while a write is stalled
      base_addr = 32'h3000; buf_len = 32'd64; ctrl = 32'h4;
      step();
      ctrl = 32'h0;
      bus.avm_waitrequest = 1'b1;
      send_beat(32'hE000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
      check("rstw_wr_up", bus.avm_write, 1);
      step();
      reset = 1'b0;
      step();
      check("rstw_state", state, 2'b00);
      check("rstw_wr", bus.avm_write, 0);
      check("rstw_ready", bus.st_ready, 0);
      check("rstw_addr", bus.avm_address, 0);
      check("rstw_wdata", bus.avm_writedata, 0);
      check("rstw_caplen", captured_len, 0);
      check("rstw_ovf", overflow, 0);
      reset = 1'b1;
      bus.avm_waitrequest = 1'b0;
      step(2);
      check("rstw_idle_after", state, 2'b00);
      check("rstw_nwr", wr_count, 0);

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
